// File: rtl/wb_hazard_ctrl.sv
`timescale 1ns/1ps
// Hazard unit for the 5-stage MIPS core: tracks E/M/W register writes, raises the D stall,
// forwards D/E operands and drives the GRF write port. Define HAZ_PERF_CNT_EN for stall_cnt.
module wb_hazard_ctrl #(
    parameter int TW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          d_issue,
    input  logic [4:0]    d_rs,
    input  logic [4:0]    d_rt,
    input  logic [TW-1:0] d_rs_tuse,
    input  logic [TW-1:0] d_rt_tuse,
    input  logic [4:0]    d_a3,
    input  logic          d_we,
    input  logic [TW-1:0] d_tnew,
    input  logic [31:0]   d_wd,
    input  logic [31:0]   d_pc,
    input  logic [31:0]   e_res,
    input  logic [31:0]   m_ld,
    input  logic [31:0]   grf_rd1,
    input  logic [31:0]   grf_rd2,
    output logic          stall,
    output logic [31:0]   d_rs_val,
    output logic [31:0]   d_rt_val,
    output logic [31:0]   e_rs_val,
    output logic [31:0]   e_rt_val,
    output logic [4:0]    grf_a3,
    output logic [31:0]   grf_wd,
    output logic          grf_we,
    output logic [31:0]   grf_pc
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]   stall_cnt
`endif
);
    typedef struct packed {
        logic          valid;
        logic          we;
        logic [4:0]    a3;
        logic [TW-1:0] tnew;
        logic [31:0]   wd;
        logic [31:0]   pc;
    } rec_t;

    localparam logic [TW-1:0] TUSE_NONE = '1;
    localparam logic [TW-1:0] TNEW_ONE  = TW'(1);

    rec_t e_q, m_q, w_q;
    rec_t e_d, m_d, w_d;

    logic [1:0]          src_stall;
    logic [1:0][4:0]     src_idx;
    logic [1:0][TW-1:0]  src_tuse;
    logic [1:0][31:0]    src_grf;
    logic [1:0][31:0]    d_fwd;
    logic [1:0][31:0]    e_fwd;

    // Slot 0 carries rs, slot 1 carries rt.
    assign src_idx  = {d_rt, d_rs};
    assign src_tuse = {d_rt_tuse, d_rs_tuse};
    assign src_grf  = {grf_rd2, grf_rd1};

    function automatic logic hit(input rec_t r, input logic [4:0] idx);
        return r.valid && r.we && (r.a3 == idx) && (idx != 5'd0);
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            logic [4:0]  e_src_q;
            logic [31:0] e_val_q;
            logic [31:0] d_fwd_l;
            logic [31:0] e_fwd_l;

            always_ff @(posedge clk) begin
                if (rst) begin
                    e_src_q <= '0;
                    e_val_q <= '0;
                end else begin
                    e_src_q <= src_idx[gi];
                    e_val_q <= d_fwd[gi];
                end
            end

            assign src_stall[gi] = (src_tuse[gi] != TUSE_NONE) &&
                ((hit(e_q, src_idx[gi]) && (e_q.tnew > src_tuse[gi])) ||
                 (hit(m_q, src_idx[gi]) && (m_q.tnew > src_tuse[gi])));

            always_comb begin
                d_fwd_l = src_grf[gi];
                if (src_idx[gi] == 5'd0)
                    d_fwd_l = '0;
                else if (hit(e_q, src_idx[gi]) && (e_q.tnew == '0))
                    d_fwd_l = e_q.wd;
                else if (hit(m_q, src_idx[gi]) && (m_q.tnew == '0))
                    d_fwd_l = m_q.wd;
                else if (hit(w_q, src_idx[gi]))
                    d_fwd_l = w_q.wd;
            end

            // W must be forwarded: the GRF only commits it on the coming edge.
            always_comb begin
                e_fwd_l = e_val_q;
                if (hit(m_q, e_src_q) && (m_q.tnew == '0))
                    e_fwd_l = m_q.wd;
                else if (hit(w_q, e_src_q))
                    e_fwd_l = w_q.wd;
            end

            assign d_fwd[gi] = d_fwd_l;
            assign e_fwd[gi] = e_fwd_l;
        end
    endgenerate

    assign stall = !rst && (|src_stall);

    always_comb begin
        e_d = '0;
        if (d_issue && !stall) begin
            e_d.valid = 1'b1;
            e_d.we    = d_we;
            e_d.a3    = d_a3;
            e_d.tnew  = d_tnew;
            e_d.wd    = d_wd;
            e_d.pc    = d_pc;
        end

        m_d      = e_q;
        m_d.tnew = (e_q.tnew == '0) ? '0 : e_q.tnew - TNEW_ONE;
        m_d.wd   = (e_q.tnew == TNEW_ONE) ? e_res : e_q.wd;

        w_d      = m_q;
        w_d.tnew = '0;
        w_d.wd   = (m_q.tnew == TNEW_ONE) ? m_ld : m_q.wd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            e_q <= e_d;
            m_q <= m_d;
            w_q <= w_d;
        end
    end

    assign d_rs_val = d_fwd[0];
    assign d_rt_val = d_fwd[1];
    assign e_rs_val = e_fwd[0];
    assign e_rt_val = e_fwd[1];

    // Gated by rst so an in-flight write never lands during the reset cycle.
    assign grf_we = !rst && w_q.valid && w_q.we;
    assign grf_a3 = w_q.a3;
    assign grf_wd = w_q.wd;
    assign grf_pc = w_q.pc;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt_q <= '0;
        else if (stall)
            stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_wb_hazard_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for wb_hazard_ctrl: directed scenarios plus randomized instruction
// streams checked against an issue-history model of the Tuse/Tnew and forwarding rules.
module tb_wb_hazard_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        d_issue;
    logic [4:0]  d_rs, d_rt, d_a3;
    logic [1:0]  d_rs_tuse, d_rt_tuse, d_tnew;
    logic        d_we;
    logic [31:0] d_wd, d_pc, e_res, m_ld, grf_rd1, grf_rd2;
    logic        stall, grf_we;
    logic [31:0] d_rs_val, d_rt_val, e_rs_val, e_rt_val, grf_wd, grf_pc;
    logic [4:0]  grf_a3;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt;
`endif

    wb_hazard_ctrl #(.TW(2)) dut (
        .clk(clk), .rst(rst), .d_issue(d_issue), .d_rs(d_rs), .d_rt(d_rt),
        .d_rs_tuse(d_rs_tuse), .d_rt_tuse(d_rt_tuse), .d_a3(d_a3), .d_we(d_we),
        .d_tnew(d_tnew), .d_wd(d_wd), .d_pc(d_pc), .e_res(e_res), .m_ld(m_ld),
        .grf_rd1(grf_rd1), .grf_rd2(grf_rd2), .stall(stall), .d_rs_val(d_rs_val),
        .d_rt_val(d_rt_val), .e_rs_val(e_rs_val), .e_rt_val(e_rt_val),
        .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_we(grf_we), .grf_pc(grf_pc)
`ifdef HAZ_PERF_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(int i);
        return (i == 0) ? 32'd0 : 32'hA5A5_0000 + 32'(i);
    endfunction

    // Environment register file: writes on the edge, reads return the pre-edge value.
    logic [31:0] regs [32];
    assign grf_rd1 = regs[d_rs];
    assign grf_rd2 = regs[d_rt];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= pat(i);
        end else if (grf_we && grf_a3 != 5'd0) begin
            regs[grf_a3] <= grf_wd;
        end
    end

    typedef struct {
        int         c;
        bit         we;
        bit [4:0]   a3;
        bit [1:0]   tnew;
        bit [31:0]  val;
        bit [31:0]  pc;
        bit [4:0]   rs, rt;
        bit [1:0]   rs_tu, rt_tu;
        bit [31:0]  exp_rs, exp_rt;
    } ins_t;

    ins_t        hist[$];
    logic [31:0] arch [32];
    int          cyc = 0, seq = 0, n_tests = 0, n_fail = 0;
    int unsigned model_stalls = 0;

    bit          t_issue, t_we;
    bit [4:0]    t_rs, t_rt, t_a3;
    bit [1:0]    t_rs_tu, t_rt_tu, t_tnew;
    bit [31:0]   t_val, t_pc;

    bit          exp_stall, exp_we, accept;
    bit [4:0]    exp_a3;
    bit [31:0]   exp_wd, exp_pc, exp_e_rs, exp_e_rt, exp_d_rs, exp_d_rt;
    bit          chk_e_rs, chk_e_rt, chk_d_rs, chk_d_rt;

    task automatic set_idle();
        t_issue = 0; t_we = 0; t_a3 = 0; t_tnew = 0; t_val = 0;
        t_rs = 0; t_rt = 0; t_rs_tu = 3; t_rt_tu = 3;
    endtask

    task automatic set_ins(input bit we, input bit [4:0] a3, input bit [1:0] tnew,
                           input bit [31:0] val, input bit [4:0] rs, input bit [1:0] rs_tu,
                           input bit [4:0] rt, input bit [1:0] rt_tu);
        t_issue = 1; t_we = we; t_a3 = a3; t_tnew = tnew; t_val = val;
        t_rs = rs; t_rs_tu = rs_tu; t_rt = rt; t_rt_tu = rt_tu;
        t_pc = 32'h0040_0000 + 32'(seq * 4);
        seq++;
    endtask

    function automatic int find_at(int c);
        foreach (hist[i]) if (hist[i].c == c) return i;
        return -1;
    endfunction

    // Result remaining for an instruction accepted 'age' cycles ago: tnew counts down from E.
    function automatic bit src_hazard(bit [4:0] r, bit [1:0] tu);
        int age, rem;
        if (tu == 2'd3 || r == 5'd0) return 0;
        foreach (hist[i]) begin
            age = cyc - hist[i].c;
            if (hist[i].we && hist[i].a3 == r && (age == 1 || age == 2)) begin
                rem = int'(hist[i].tnew) - (age - 1);
                if (rem > int'(tu)) return 1;
            end
        end
        return 0;
    endfunction

    // Drive one cycle's inputs (just after negedge) and derive what the DUT must show.
    task automatic prep();
        int ie, im, iw;
        ie = find_at(cyc - 1);
        im = find_at(cyc - 2);
        iw = find_at(cyc - 3);
        d_issue = t_issue; d_rs = t_rs; d_rt = t_rt; d_rs_tuse = t_rs_tu; d_rt_tuse = t_rt_tu;
        d_a3 = t_a3; d_we = t_we; d_tnew = t_tnew; d_pc = t_pc;
        d_wd  = (t_tnew == 2'd0) ? t_val : $urandom;
        e_res = (ie >= 0 && hist[ie].tnew == 2'd1) ? hist[ie].val : $urandom;
        m_ld  = (im >= 0 && hist[im].tnew == 2'd2) ? hist[im].val : $urandom;
        #1;
        exp_stall = !rst && (src_hazard(t_rs, t_rs_tu) || src_hazard(t_rt, t_rt_tu));
        accept    = !rst && t_issue && !exp_stall;
        exp_we    = !rst && iw >= 0 && hist[iw].we;
        exp_a3    = (iw >= 0) ? hist[iw].a3 : 5'd0;
        exp_wd    = (iw >= 0) ? hist[iw].val : 32'd0;
        exp_pc    = (iw >= 0) ? hist[iw].pc : 32'd0;
        chk_e_rs  = !rst && ie >= 0 && hist[ie].rs_tu <= 2'd1;
        chk_e_rt  = !rst && ie >= 0 && hist[ie].rt_tu <= 2'd1;
        exp_e_rs  = (ie >= 0) ? hist[ie].exp_rs : 32'd0;
        exp_e_rt  = (ie >= 0) ? hist[ie].exp_rt : 32'd0;
        chk_d_rs  = accept && t_rs_tu == 2'd0;
        chk_d_rt  = accept && t_rt_tu == 2'd0;
        exp_d_rs  = arch[t_rs];
        exp_d_rt  = arch[t_rt];
    endtask

    task automatic advance();
        ins_t n;
        @(posedge clk);
        if (rst) begin
            hist.delete();
            for (int i = 0; i < 32; i++) arch[i] = pat(i);
            model_stalls = 0;
        end else begin
            if (exp_stall) model_stalls++;
            if (accept) begin
                n.c = cyc; n.we = t_we; n.a3 = t_a3; n.tnew = t_tnew; n.val = t_val; n.pc = t_pc;
                n.rs = t_rs; n.rt = t_rt; n.rs_tu = t_rs_tu; n.rt_tu = t_rt_tu;
                n.exp_rs = arch[t_rs]; n.exp_rt = arch[t_rt];
                hist.push_back(n);
                if (t_we && t_a3 != 5'd0) arch[t_a3] = t_val;
            end
        end
        while (hist.size() > 0 && hist[0].c < cyc - 4) void'(hist.pop_front());
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain(int n);
        set_idle();
        repeat (n) begin prep(); advance(); end
    endtask

    task automatic test_reset();
        rst = 1; set_idle();
        repeat (2) begin
            prep();
            n_tests++; if (stall !== 1'b0 || grf_we !== 1'b0) begin n_fail++; $display("FAIL reset_hold: stall=%b grf_we=%b want 0/0", stall, grf_we); end
            advance();
        end
        rst = 0;
        prep();
        n_tests++; if ({grf_a3, grf_wd, grf_pc} !== '0) begin n_fail++; $display("FAIL reset_grf: a3=%0d wd=%h pc=%h want zeros", grf_a3, grf_wd, grf_pc); end
        n_tests++; if ({e_rs_val, e_rt_val, d_rs_val} !== '0) begin n_fail++; $display("FAIL reset_vals: e_rs=%h e_rt=%h d_rs=%h want zeros", e_rs_val, e_rt_val, d_rs_val); end
`ifdef HAZ_PERF_CNT_EN
        n_tests++; if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
`endif
        for (int i = 0; i < 5; i++) begin
            if (i > 0) prep();
            n_tests++; if (stall !== 1'b0 || grf_we !== 1'b0) begin n_fail++; $display("FAIL idle_%0d: stall=%b grf_we=%b want 0/0", i, stall, grf_we); end
            advance();
        end
    endtask

    task automatic test_alu_fwd();
        bit [31:0] pc0;
        set_ins(1, 8, 1, 32'h5, 0, 3, 0, 3); pc0 = t_pc;
        prep(); advance();
        set_ins(0, 0, 1, $urandom, 8, 1, 0, 3);
        prep();
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL alu_stall: got %b want 0", stall); end
        advance();
        set_idle(); prep();
        n_tests++; if (e_rs_val !== 32'h5) begin n_fail++; $display("FAIL alu_e_fwd: got %h want 00000005", e_rs_val); end
        advance();
        prep();
        n_tests++; if (grf_we !== 1'b1 || grf_a3 !== 5'd8 || grf_wd !== 32'h5 || grf_pc !== pc0) begin
            n_fail++; $display("FAIL alu_grf: we=%b a3=%0d wd=%h pc=%h want 1/8/00000005/%h", grf_we, grf_a3, grf_wd, grf_pc, pc0); end
        advance();
        drain(2);
    endtask

    task automatic test_load_use();
        set_ins(1, 9, 2, 32'hDEADBEEF, 0, 3, 0, 3);
        prep(); advance();
        set_ins(1, 10, 1, 32'h11, 9, 1, 0, 3);
        prep();
        n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall1: got %b want 1", stall); end
        advance(); prep();
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_stall2: got %b want 0", stall); end
        advance(); set_idle(); prep();
        n_tests++; if (e_rs_val !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lu_e_fwd: got %h want deadbeef", e_rs_val); end
        n_tests++; if (grf_we !== 1'b1 || grf_a3 !== 5'd9 || grf_wd !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL lu_grf_load: we=%b a3=%0d wd=%h want 1/9/deadbeef", grf_we, grf_a3, grf_wd); end
        advance(); prep();
        n_tests++; if (grf_we !== 1'b0) begin n_fail++; $display("FAIL lu_bubble: grf_we=%b want 0", grf_we); end
        advance(); prep();
        n_tests++; if (grf_we !== 1'b1 || grf_a3 !== 5'd10 || grf_wd !== 32'h11) begin
            n_fail++; $display("FAIL lu_grf_user: we=%b a3=%0d wd=%h want 1/10/00000011", grf_we, grf_a3, grf_wd); end
        advance();
        drain(2);
    endtask

    task automatic test_branch_after_load();
        set_ins(1, 9, 2, 32'hCAFEF00D, 0, 3, 0, 3);
        prep(); advance();
        set_ins(0, 0, 0, 32'h0, 9, 0, 0, 3);
        for (int i = 0; i < 3; i++) begin
            prep();
            n_tests++; if (stall !== (i < 2)) begin n_fail++; $display("FAIL br_stall_%0d: got %b want %b", i, stall, (i < 2)); end
            if (i == 2) begin
                n_tests++; if (d_rs_val !== 32'hCAFEF00D) begin n_fail++; $display("FAIL br_w_fwd: got %h want cafef00d", d_rs_val); end
            end
            advance();
        end
        drain(3);
    endtask

    task automatic test_zero_and_priority();
        set_ins(1, 0, 1, 32'h77, 0, 3, 0, 3);
        prep(); advance();
        set_ins(0, 0, 0, 32'h0, 0, 0, 0, 0);
        prep();
        n_tests++; if (stall !== 1'b0 || d_rs_val !== 32'd0) begin n_fail++; $display("FAIL zero_read: stall=%b d_rs=%h want 0/00000000", stall, d_rs_val); end
        advance();
        drain(3);
        set_ins(1, 3, 0, 32'h1, 0, 3, 0, 3); prep(); advance();
        set_ins(1, 3, 0, 32'h2, 0, 3, 0, 3); prep(); advance();
        set_ins(0, 0, 0, 32'h0, 3, 0, 0, 3);
        prep();
        n_tests++; if (stall !== 1'b0 || d_rs_val !== 32'h2) begin n_fail++; $display("FAIL prio_e_over_m: stall=%b d_rs=%h want 0/00000002", stall, d_rs_val); end
        advance();
        set_ins(0, 0, 0, 32'h0, 0, 3, 3, 0);
        prep();
        n_tests++; if (d_rt_val !== 32'h2) begin n_fail++; $display("FAIL prio_m_over_w: d_rt=%h want 00000002", d_rt_val); end
        advance();
        drain(3);
    endtask

    task automatic test_random();
        bit pending = 0;
        for (int n = 0; n < 600; n++) begin
            if (!pending) begin
                if ($urandom_range(0, 9) < 8)
                    set_ins($urandom_range(0, 9) < 8, 5'($urandom_range(0, 4)), 2'($urandom_range(0, 2)), $urandom,
                            5'($urandom_range(0, 4)), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 4)), 2'($urandom_range(0, 3)));
                else
                    set_idle();
                pending = 1;
            end
            prep();
            n_tests++; if (stall !== exp_stall) begin n_fail++; $display("FAIL rnd_stall c%0d: got %b want %b", cyc, stall, exp_stall); end
            n_tests++; if (grf_we !== exp_we) begin n_fail++; $display("FAIL rnd_grf_we c%0d: got %b want %b", cyc, grf_we, exp_we); end
            if (exp_we) begin
                n_tests++; if (grf_a3 !== exp_a3 || grf_wd !== exp_wd || grf_pc !== exp_pc) begin
                    n_fail++; $display("FAIL rnd_grf c%0d: a3=%0d wd=%h pc=%h want %0d/%h/%h", cyc, grf_a3, grf_wd, grf_pc, exp_a3, exp_wd, exp_pc); end
            end
            if (chk_d_rs) begin
                n_tests++; if (d_rs_val !== exp_d_rs) begin n_fail++; $display("FAIL rnd_d_rs c%0d: got %h want %h", cyc, d_rs_val, exp_d_rs); end
            end
            if (chk_d_rt) begin
                n_tests++; if (d_rt_val !== exp_d_rt) begin n_fail++; $display("FAIL rnd_d_rt c%0d: got %h want %h", cyc, d_rt_val, exp_d_rt); end
            end
            if (chk_e_rs) begin
                n_tests++; if (e_rs_val !== exp_e_rs) begin n_fail++; $display("FAIL rnd_e_rs c%0d: got %h want %h", cyc, e_rs_val, exp_e_rs); end
            end
            if (chk_e_rt) begin
                n_tests++; if (e_rt_val !== exp_e_rt) begin n_fail++; $display("FAIL rnd_e_rt c%0d: got %h want %h", cyc, e_rt_val, exp_e_rt); end
            end
`ifdef HAZ_PERF_CNT_EN
            n_tests++; if (stall_cnt !== 32'(model_stalls)) begin n_fail++; $display("FAIL rnd_stall_cnt c%0d: got %0d want %0d", cyc, stall_cnt, model_stalls); end
`endif
            advance();
            if (!t_issue || accept) pending = 0;
        end
        drain(4);
    endtask

    task automatic test_reset_midflight();
        for (int i = 0; i < 3; i++) begin
            set_ins(1, 5'(5 + i), 1, 32'h100 + 32'(i), 0, 3, 0, 3);
            prep(); advance();
        end
        rst = 1; set_idle(); prep();
        n_tests++; if (grf_we !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL mid_rst_cycle: grf_we=%b stall=%b want 0/0", grf_we, stall); end
        advance();
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            prep();
            n_tests++; if (grf_we !== 1'b0) begin n_fail++; $display("FAIL mid_after_%0d: grf_we=%b want 0", i, grf_we); end
`ifdef HAZ_PERF_CNT_EN
            n_tests++; if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL mid_stall_cnt_%0d: got %0d want 0", i, stall_cnt); end
`endif
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_alu_fwd();
        test_load_use();
        test_branch_after_load();
        test_zero_and_priority();
        test_random();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end
endmodule
